// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath defaults, tap packing order and round/saturate helper
// Contents:
//   DATA_W_DEF / ACC_W_DEF  default tap/weight and accumulator widths
//   TAP0_MSB                tap 0 (row0,col0) sits in the MSBs of a packed window
//   rs_t / round_sat        round-half-up, arithmetic shift, clip to a signed width
package cnn_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF = 40;
  localparam bit TAP0_MSB = 1'b1;
  typedef struct packed {
    logic sat;
    logic signed [63:0] val;
  } rs_t;
  function automatic rs_t round_sat(input logic signed [63:0] x, input int fs, input int ow);
    logic signed [63:0] r, hi, lo;
    rs_t o;
    r = fs > 0 ? (x + (64'sd1 <<< (fs - 1))) >>> fs : x;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    o.sat = r > hi || r < lo;
    o.val = r > hi ? hi : r < lo ? lo : r;
    return o;
  endfunction
endpackage

// File: rtl/conv_mult_tree.sv
// conv_mult_tree: N registered signed multipliers feeding a registered adder tree (2-cycle latency)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid           operands present; registers hold when low
//   i_a, i_b          N packed signed DATA_W operands, element 0 in the MSBs
//   o_valid, o_sum    sum of the N products sign-extended to ACC_W, two cycles after i_valid
module conv_mult_tree
  import cnn_pkg::*;
#(
  parameter int N = 9,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [N*DATA_W-1:0]     i_a,
  input  logic [N*DATA_W-1:0]     i_b,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] o_sum
);
  logic signed [2*DATA_W-1:0] r_prod [N];
  logic r_pv;
  logic signed [ACC_W-1:0] w_sum;
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pv <= 1'b0;
      o_valid <= 1'b0;
      o_sum <= '0;
      for (int k = 0; k < N; k++) r_prod[k] <= '0;
    end else begin
      r_pv <= i_valid;
      o_valid <= r_pv;
      if (i_valid)
        for (int k = 0; k < N; k++)
          r_prod[k] <= $signed(i_a[(TAP0_MSB ? N - 1 - k : k)*DATA_W +: DATA_W]) *
                       $signed(i_b[(TAP0_MSB ? N - 1 - k : k)*DATA_W +: DATA_W]);
      if (r_pv) o_sum <= w_sum;
    end
endmodule

// File: rtl/conv2d_mc_acc.sv
// conv2d_mc_acc: KSIZE x KSIZE multi-channel convolution accumulator with bias, rounding and saturation
// Build option: define CONV2D_MC_RELU_EN to clamp negative results to 0 after saturation.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_vsync, in_href               frame/line sync levels; a vsync rising edge restarts the channel count
//   in_valid, in_window, in_weight  one channel beat of packed taps/weights (tap 0 in the MSBs)
//   in_bias, in_h_cnt, in_v_cnt     sampled on the last-channel beat
//   out_valid, out_data, out_sat    result pulse 3 cycles after the last beat; data/sat hold between pulses
//   out_h_cnt, out_v_cnt            coordinates of out_data
//   out_href, out_vsync             sync inputs delayed 3 cycles
//   ch_idx                          channel expected on the next beat
module conv2d_mc_acc
  import cnn_pkg::*;
#(
  parameter int KSIZE = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int BIAS_W = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W = 16,
  parameter int CNT_W = 7,
  localparam int N = KSIZE * KSIZE,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vsync,
  input  logic                     in_href,
  input  logic                     in_valid,
  input  logic [N*DATA_W-1:0]      in_window,
  input  logic [N*DATA_W-1:0]      in_weight,
  input  logic signed [BIAS_W-1:0] in_bias,
  input  logic [CNT_W-1:0]         in_h_cnt,
  input  logic [CNT_W-1:0]         in_v_cnt,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         out_h_cnt,
  output logic [CNT_W-1:0]         out_v_cnt,
  output logic                     out_href,
  output logic                     out_vsync,
  output logic [CH_W-1:0]          ch_idx
);
  logic r_vs_prev, r1_vld, r1_first, r1_last, r2_first, r2_last;
  logic [2:0] r_href_d, r_vsync_d;
  logic signed [BIAS_W-1:0] r1_bias, r2_bias;
  logic [CNT_W-1:0] r1_h, r1_v, r2_h, r2_v;
  logic signed [ACC_W-1:0] r_acc, w_sum, w_part, w_tot;
  logic w_fs, w_last, w_s2v, w_qs, w_unused;
  logic [CH_W-1:0] w_ch;
  logic signed [OUT_W-1:0] w_q;
  rs_t w_rs;
  conv_mult_tree #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_tree (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .i_a(in_window), .i_b(in_weight),
    .o_valid(w_s2v), .o_sum(w_sum)
  );
  // a vsync rising edge makes this cycle's beat (if any) channel 0
  assign w_fs = in_vsync & ~r_vs_prev;
  assign w_ch = w_fs ? '0 : ch_idx;
  assign w_last = w_ch == CH_W'(NUM_CH - 1);
  assign out_href = r_href_d[2];
  assign out_vsync = r_vsync_d[2];
  // the first flag drops whatever partial sum a restarted pixel left behind
  assign w_part = (r2_first ? '0 : r_acc) + w_sum;
  assign w_tot = w_part + ACC_W'(r2_bias);
  assign w_rs = round_sat(64'(w_tot), FRAC_SHIFT, OUT_W);
  assign w_unused = ^w_rs.val;
`ifdef CONV2D_MC_RELU_EN
  assign w_q = w_rs.val[63] ? '0 : w_rs.val[OUT_W-1:0];
  assign w_qs = w_rs.sat & ~w_rs.val[63];
`else
  assign w_q = w_rs.val[OUT_W-1:0];
  assign w_qs = w_rs.sat;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_href_d <= '0;
      r_vsync_d <= '0;
      ch_idx <= '0;
      r1_vld <= 1'b0;
      r1_first <= 1'b0;
      r1_last <= 1'b0;
      r1_bias <= '0;
      r1_h <= '0;
      r1_v <= '0;
      r2_first <= 1'b0;
      r2_last <= 1'b0;
      r2_bias <= '0;
      r2_h <= '0;
      r2_v <= '0;
      r_acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      out_h_cnt <= '0;
      out_v_cnt <= '0;
    end else begin
      r_vs_prev <= in_vsync;
      r_href_d <= {r_href_d[1:0], in_href};
      r_vsync_d <= {r_vsync_d[1:0], in_vsync};
      if (in_valid || w_fs) ch_idx <= in_valid && !w_last ? w_ch + 1'b1 : '0;
      r1_vld <= in_valid;
      if (in_valid) begin
        r1_first <= w_ch == '0;
        r1_last <= w_last;
      end
      if (in_valid && w_last) begin
        r1_bias <= in_bias;
        r1_h <= in_h_cnt;
        r1_v <= in_v_cnt;
      end
      if (r1_vld) begin
        r2_first <= r1_first;
        r2_last <= r1_last;
        r2_bias <= r1_bias;
        r2_h <= r1_h;
        r2_v <= r1_v;
      end
      if (w_s2v) r_acc <= w_part;
      out_valid <= w_s2v && r2_last;
      if (w_s2v && r2_last) begin
        out_data <= w_q;
        out_sat <= w_qs;
        out_h_cnt <= r2_h;
        out_v_cnt <= r2_v;
      end
    end
endmodule

// File: tb/tb_conv2d_mc_acc.sv
// tb_conv2d_mc_acc: scoreboard bench for a 4-channel (shift 8) and a 1-channel (shift 0) instance
`timescale 1ns/1ps
module tb_conv2d_mc_acc;
  localparam int DW = 16;
  localparam int NT = 9;
  localparam int WW = NT * DW;
  typedef struct {
    int d;
    bit s;
    int h;
    int v;
    int c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic hr = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [WW-1:0] win0 = '0, wt0 = '0, win1 = '0, wt1 = '0;
  logic signed [31:0] b0 = '0, b1 = '0;
  logic [6:0] h0 = '0, vc0 = '0, h1 = '0, vc1 = '0;
  logic ov0, os0, ohr0, ovs0, ov1, os1, ohr1, ovs1;
  logic signed [15:0] od0, od1;
  logic [6:0] oh0, ovc0, oh1, ovc1;
  logic [1:0] ch0;
  logic [0:0] ch1;
  exp_t q0[$], q1[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic [2:0] hh = '0, hv = '0;
  int hn = 0;
  bit streaming = 1'b0;
  always #5 clk = ~clk;
  conv2d_mc_acc u0 (
    .clk(clk), .rst_n(rst_n), .in_vsync(vs), .in_href(hr), .in_valid(v0),
    .in_window(win0), .in_weight(wt0), .in_bias(b0), .in_h_cnt(h0), .in_v_cnt(vc0),
    .out_valid(ov0), .out_data(od0), .out_sat(os0), .out_h_cnt(oh0), .out_v_cnt(ovc0),
    .out_href(ohr0), .out_vsync(ovs0), .ch_idx(ch0)
  );
  conv2d_mc_acc #(.NUM_CH(1), .FRAC_SHIFT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_vsync(vs), .in_href(hr), .in_valid(v1),
    .in_window(win1), .in_weight(wt1), .in_bias(b1), .in_h_cnt(h1), .in_v_cnt(vc1),
    .out_valid(ov1), .out_data(od1), .out_sat(os1), .out_h_cnt(oh1), .out_v_cnt(ovc1),
    .out_href(ohr1), .out_vsync(ovs1), .ch_idx(ch1)
  );
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t mk(input int d, input bit s, input int h, input int v, input int c);
    exp_t e;
`ifdef CONV2D_MC_RELU_EN
    if (d < 0) begin
      d = 0;
      s = 1'b0;
    end
`endif
    e.d = d; e.s = s; e.h = h; e.v = v; e.c = c;
    return e;
  endfunction
  function automatic logic [WW-1:0] pk(input int t[NT]);
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < NT; k++) r[(NT-1-k)*DW +: DW] = DW'(t[k]);
    return r;
  endfunction
  function automatic logic [WW-1:0] ctr(input int x);
    logic [WW-1:0] r;
    r = '0;
    r[4*DW +: DW] = DW'(x);
    return r;
  endfunction
  function automatic logic [WW-1:0] fill(input int x);
    logic [WW-1:0] r;
    for (int k = 0; k < NT; k++) r[k*DW +: DW] = DW'(x);
    return r;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic beat0(input logic [WW-1:0] w, input logic [WW-1:0] k, input int b, input int h, input int v);
    win0 = w; wt0 = k; b0 = b; h0 = 7'(h); vc0 = 7'(v); v0 = 1'b1;
    idle(1);
    v0 = 1'b0;
  endtask
  task automatic pix0(input logic [WW-1:0] a0, input logic [WW-1:0] a1, input logic [WW-1:0] a2,
                      input logic [WW-1:0] a3, input logic [WW-1:0] k, input int b, input int h,
                      input int v, input int d, input bit s, input int gap);
    logic [WW-1:0] w[4];
    w = '{a0, a1, a2, a3};
    for (int c = 0; c < 4; c++) begin
      if (c == 3) q0.push_back(mk(d, s, h, v, cyc + 3));
      beat0(w[c], k, b, h, v);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask
  task automatic beat1(input logic [WW-1:0] w, input logic [WW-1:0] k, input int b, input int h,
                       input int v, input int d, input bit s);
    q1.push_back(mk(d, s, h, v, cyc + 3));
    win1 = w; wt1 = k; b1 = b; h1 = 7'(h); vc1 = 7'(v); v1 = 1'b1;
    idle(1);
    v1 = 1'b0;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (!rst_n) hn <= 0;
    else begin
      hh <= {hh[1:0], hr};
      hv <= {hv[1:0], vs};
      if (hn < 3) hn <= hn + 1;
    end
  always @(negedge clk)
    if (rst_n && hn == 3) begin
      chk("out_href delay", ohr0, hh[2]);
      chk("out_vsync delay", ovs0, hv[2]);
    end
  always @(negedge clk)
    if (rst_n && ov0 === 1'b1) begin
      exp_t e;
      if (q0.size() == 0) chk("dut0 unexpected out_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0 out_data", od0, e.d);
        chk("dut0 out_sat", os0, e.s);
        chk("dut0 out_h_cnt", oh0, e.h);
        chk("dut0 out_v_cnt", ovc0, e.v);
        chk("dut0 latency", cyc, e.c);
      end
    end
  always @(negedge clk)
    if (rst_n && ov1 === 1'b1) begin
      exp_t e;
      if (q1.size() == 0) chk("dut1 unexpected out_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1 out_data", od1, e.d);
        chk("dut1 out_sat", os1, e.s);
        chk("dut1 out_h_cnt", oh1, e.h);
        chk("dut1 out_v_cnt", ovc1, e.v);
        chk("dut1 latency", cyc, e.c);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [WW-1:0] z, w256, t19, tn19;
    z = '0;
    w256 = fill(256);
    t19 = pk('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    tn19 = pk('{-1, -2, -3, -4, -5, -6, -7, -8, -9});
    idle(3);
    @(negedge clk);
    chk("reset out_valid", ov0, 0);
    chk("reset out_data", od0, 0);
    chk("reset out_sat", os0, 0);
    chk("reset ch_idx", ch0, 0);
    chk("reset out_href", ohr0, 0);
    chk("reset dut1 out_valid", ov1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    pix0(ctr(10), ctr(20), ctr(30), ctr(40), ctr(256), 0, 5, 6, 100, 0, 0);
    chk("ch_idx after pixel", ch0, 0);
    idle(4);
    pix0(z, z, z, z, z, 32'h7FFF80, 1, 1, 32767, 1, 0);
    pix0(z, z, z, z, z, -384, 2, 1, -1, 0, 0);
    pix0(z, z, z, z, z, -300, 3, 1, -1, 0, 0);
    pix0(z, z, z, z, z, -32'sh900000, 4, 1, -32768, 1, 0);
    pix0(t19, t19, t19, t19, w256, 256, 5, 1, 181, 0, 0);
    pix0(tn19, tn19, tn19, tn19, w256, 0, 6, 1, -180, 0, 0);
    idle(5);
    beat0(ctr(1000), ctr(256), 0, 0, 0);
    beat0(ctr(1000), ctr(256), 0, 0, 0);
    chk("ch_idx mid pixel", ch0, 2);
    vs = 1'b1;
    pix0(ctr(1), ctr(2), ctr(3), ctr(4), ctr(256), 0, 9, 9, 10, 0, 0);
    idle(3);
    vs = 1'b0;
    idle(3);
    streaming = 1'b1;
    fork
      while (streaming) begin
        hr = 1'($urandom_range(0, 1));
        idle(1);
      end
      begin
        for (int p = 0; p < 8; p++)
          pix0(ctr(p + 1), ctr(p + 1), ctr(p + 1), ctr(p + 1), ctr(256), 0, p, 3, 4 * (p + 1), 0, 2);
        idle(5);
        streaming = 1'b0;
      end
    join
    hr = 1'b1;
    beat0(ctr(50), ctr(256), 0, 0, 0);
    beat0(ctr(50), ctr(256), 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset out_valid", ov0, 0);
    chk("mid reset out_data", od0, 0);
    chk("mid reset out_sat", os0, 0);
    chk("mid reset out_h_cnt", oh0, 0);
    chk("mid reset out_v_cnt", ovc0, 0);
    chk("mid reset ch_idx", ch0, 0);
    chk("mid reset out_href", ohr0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    pix0(ctr(5), ctr(5), ctr(5), ctr(5), ctr(256), 0, 1, 2, 20, 0, 0);
    idle(4);
    beat1(t19, fill(1), 5, 12, 34, 50, 0);
    beat1(fill(1000), fill(1000), 0, 13, 34, 32767, 1);
    beat1(tn19, fill(1), 0, 14, 34, -45, 0);
    beat1(fill(-1000), fill(1000), 0, 15, 34, -32768, 1);
    idle(8);
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv2d_mc_acc.md
Name: conv2d_mc_acc

Overview:
- Parametrised successor to the fixed 3x3 single-channel convolution core: KSIZE x KSIZE window, configurable data width, and multi-input-channel accumulation.
- Accepts one window/weight beat per input channel per output pixel, accumulates NUM_CH beats, adds bias, then rounds, shifts and saturates to OUT_W.
- Sits between the line-buffer/window generator and the activation/pooling stage of the CNN feature-map pipeline.

Parameters:
- KSIZE, 3, kernel side; window holds KSIZE*KSIZE taps.
- DATA_W, 16, signed width of each feature-map tap and weight.
- NUM_CH, 4, input channels accumulated per output pixel (>=1).
- ACC_W, 40, signed accumulator width (>= 2*DATA_W + clog2(KSIZE*KSIZE*NUM_CH) + 1).
- BIAS_W, 32, signed bias width, same scale as products.
- FRAC_SHIFT, 8, arithmetic right shift applied at output (0 allowed).
- OUT_W, 16, signed output width.
- CNT_W, 7, width of the h/v pixel counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vsync  in  1  frame sync, level
- in_href  in  1  line valid, level
- in_valid  in  1  one channel beat present this cycle
- in_window  in  KSIZE*KSIZE*DATA_W  signed taps, tap 0 (row0,col0) in the MSBs
- in_weight  in  KSIZE*KSIZE*DATA_W  signed weights, same packing
- in_bias  in  BIAS_W  signed bias, sampled on the last-channel beat
- in_h_cnt, in_v_cnt  in  CNT_W each  pixel coordinates, sampled on the last-channel beat
- out_valid  out  1  one-cycle pulse, result valid
- out_data  out  OUT_W  signed result
- out_sat  out  1  result was clipped; qualified by out_valid
- out_h_cnt, out_v_cnt  out  CNT_W each  coordinates of out_data
- out_href, out_vsync  out  1 each  in_href/in_vsync delayed 3 cycles
- ch_idx  out  clog2(NUM_CH) (min 1)  channel expected on the next beat

Behaviour:
- Reset: every output and internal register is 0, including ch_idx, the accumulator and all pipeline valids.
- Channel counter:
  - Increments on each in_valid; wraps NUM_CH-1 -> 0.
  - The beat with ch_idx==NUM_CH-1 is the last beat of a pixel.
- Frame start: a rising edge of in_vsync (against a registered copy) forces ch_idx to 0 and discards any partial accumulation. If in_valid occurs in the same cycle, that beat is taken as channel 0.
- Backpressure: none. The stream is never stalled, and in_valid low holds all state.
- Stage 1 (registered):
  - Forms KSIZE*KSIZE signed DATA_W x DATA_W products, each 2*DATA_W wide.
  - Also registers valid, first flag (ch==0), last flag, and bias/h/v when last is set.
- Stage 2 (registered): sums the products, sign-extended to ACC_W.
- Stage 3 (registered), when stage-2 valid:
  - first: acc = sum; otherwise acc = acc + sum.
  - On last: total = acc_prev_or_0 + sum + sext(bias).
  - Rounding: if FRAC_SHIFT>0, add 1<<(FRAC_SHIFT-1), then arithmetic shift right by FRAC_SHIFT.
  - Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat when clipped.
  - Drive out_data/out_h_cnt/out_v_cnt and pulse out_valid.
- Latency: out_valid is asserted exactly 3 cycles after the last-channel in_valid. Back-to-back beats every cycle are supported. With NUM_CH=1, every beat produces an output.
- Holding: out_data/out_sat/out_h_cnt/out_v_cnt hold their last value while out_valid is 0.
- Sync alignment: out_href/out_vsync are a pure 3-cycle shift of the inputs, independent of in_valid.
- Reset mid-pixel: the partial sum is lost, and no out_valid is produced for in-flight beats.

Optional Feature:
- Macro: CONV2D_MC_RELU_EN.
- Defined: after saturation, negative results are replaced by 0 and out_sat reflects positive clipping only. Latency is unchanged.
- Undefined: the signed saturated result is passed through.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W and ACC_W defaults
  - the tap packing-order constant
  - a saturate/round function shared with the pooling and FC blocks
- One natural sub-module: conv_mult_tree (KSIZE*KSIZE registered multipliers plus the registered adder tree, 2-cycle latency), reusable by the FC layer.

Test Plan:
- Single-channel pass-through:
  - Setup: NUM_CH=1, FRAC_SHIFT=0, weights all 1, taps 1..9, bias 5.
  - Required: out_data=50 exactly 3 cycles after in_valid; out_h_cnt/out_v_cnt equal the sampled values.
- Four-channel accumulation:
  - Setup: NUM_CH=4, FRAC_SHIFT=8, centre weight 256 (others 0), centre taps 10,20,30,40 on consecutive cycles, bias 0.
  - Required: one out_valid, out_data=100, ch_idx returns to 0.
- Rounding and saturation:
  - Input: a window giving total 0x7FFF_80 with FRAC_SHIFT=8.
  - Required: out_data=32767, out_sat=1.
  - Input: total -0x0180.
  - Required: out_data=-1 (round-half-up then arithmetic shift), out_sat=0.
- Frame restart: send 2 of 4 channels, raise in_vsync, then 4 clean channels. Required: exactly one out_valid, and it reflects only the last 4 beats.
- Streaming with gaps and reset:
  - Stimulus: 8 pixels with random in_valid gaps.
  - Required: outputs in order, no missing or duplicate pulses, out_href/out_vsync delayed exactly 3 cycles.
  - Stimulus: assert rst_n low mid-pixel.
  - Required: all outputs are 0 on the next edge.
- RELU build (CONV2D_MC_RELU_EN defined): a negative total of -300 gives out_data=0, out_sat=0.
